uart_tx_feeder: RTL and testbench

Byte buffer and launch sequencer directly upstream of the UART transmitter, in the TX clock domain. It accepts bytes from the system side into a small FIFO. It presents them one at a time on the transmitter's P_DATA/DATA_VALID inputs, pacing launches with the transmitter's Busy output, so the system never has to watch frame timing.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 50 +++++
 rtl/uart_tx_feeder.sv | 99 +++++++++
 tb/tb_uart_tx_feeder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART TX feeder: FSM encodings, WAIT_BUSY timeout and default sizing.
package uart_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH      = 8;

  localparam logic [1:0] ST_IDLE      = 2'b00;
  localparam logic [1:0] ST_WAIT_BUSY = 2'b01;
  localparam logic [1:0] ST_WAIT_DONE = 2'b10;

  // Cycles of Busy=0 tolerated in WAIT_BUSY before the byte is treated as consumed
  localparam int unsigned WAIT_BUSY_TIMEOUT = 2;
  localparam int unsigned WAIT_CNT_W        = $clog2(WAIT_BUSY_TIMEOUT + 1);

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers, pointer-derived FULL/EMPTY and a combinational head read.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign head  = mem[rd_ptr_q[AW-1:0]];

  // Storage is not reset; reset only flushes by zeroing the pointers
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers system bytes and launches them into the UART transmitter, paced by its Busy output.
// Optional sticky overflow flag OVF when UART_TX_FEEDER_OVF_EN is defined.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  WR_EN,
  output logic                  FULL,
  output logic                  EMPTY,
  input  logic                  Busy,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_DATA_VALID
`ifdef UART_TX_FEEDER_OVF_EN
  ,
  output logic                  OVF
`endif
);

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic [WAIT_CNT_W-1:0] wait_cnt_d;
  logic                  launch_c;
  logic [DATA_WIDTH-1:0] head;

  uart_tx_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk    (CLK),
    .rst_n  (RST),
    .wr_data(WR_DATA),
    .wr_en  (WR_EN),
    .rd_en  (launch_c),
    .full   (FULL),
    .empty  (EMPTY),
    .head   (head)
  );

  // Launch sequencing; the WAIT_BUSY timeout keeps a silent transmitter from stalling the queue
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    launch_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!EMPTY && !Busy) begin
          launch_c   = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (Busy) begin
          state_d = ST_WAIT_DONE;
        end else if (wait_cnt_q == WAIT_CNT_W'(WAIT_BUSY_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!Busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      TX_DATA_VALID <= 1'b0;
      TX_P_DATA     <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      TX_DATA_VALID <= launch_c;
      if (launch_c) TX_P_DATA <= head;
    end
  end

`ifdef UART_TX_FEEDER_OVF_EN
  // Sticky until reset: any write attempted while the queue was already full
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OVF <= 1'b0;
    end else if (WR_EN && FULL) begin
      OVF <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: vector table for single-byte and timeout flows,
// hand sequences for burst, overflow, reset mid-frame and pointer wrap-around.
module tb_uart_tx_feeder;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] WR_DATA;
  logic       WR_EN;
  logic       FULL;
  logic       EMPTY;
  logic       Busy;
  logic [7:0] TX_P_DATA;
  logic       TX_DATA_VALID;
`ifdef UART_TX_FEEDER_OVF_EN
  logic       OVF;
`endif

  uart_tx_feeder #(
    .DATA_WIDTH(8),
    .DEPTH     (8)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .WR_DATA      (WR_DATA),
    .WR_EN        (WR_EN),
    .FULL         (FULL),
    .EMPTY        (EMPTY),
    .Busy         (Busy),
    .TX_P_DATA    (TX_P_DATA),
    .TX_DATA_VALID(TX_DATA_VALID)
`ifdef UART_TX_FEEDER_OVF_EN
    ,
    .OVF          (OVF)
`endif
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       busy;
    logic       exp_valid;
    logic [7:0] exp_pdata;
    logic       exp_empty;
    logic       exp_full;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // {valid, pdata, empty, full}
  function automatic logic [31:0] obs();
    return {21'd0, TX_DATA_VALID, TX_P_DATA, EMPTY, FULL};
  endfunction

  function automatic logic [31:0] pack(input logic v, input logic [7:0] d, input logic e, input logic f);
    return {21'd0, v, d, e, f};
  endfunction

  function automatic void add(input logic we, input logic [7:0] wd, input logic b,
                              input logic ev, input logic [7:0] ed, input logic ee, input logic ef);
    vec_t v;
    v.wr_en = we; v.wr_data = wd; v.busy = b;
    v.exp_valid = ev; v.exp_pdata = ed; v.exp_empty = ee; v.exp_full = ef;
    vecs.push_back(v);
  endfunction

  // Acts as the transmitter: Busy rises the cycle after each strobe and lasts frame_len cycles
  task automatic run_tx(input string name, input int frame_len, input int budget);
    int   cyc;
    int   left;
    logic busy_at_edge;
    cyc  = 0;
    left = 0;
    while (exp_q.size() > 0 && cyc < budget) begin
      busy_at_edge = Busy;
      tick();
      cyc++;
      if (left > 0) begin
        left--;
        if (left == 0) Busy = 1'b0;
      end
      if (TX_DATA_VALID) begin
        chk({name, "_data"}, 32'(TX_P_DATA), 32'(exp_q.pop_front()));
        chk({name, "_busy_gap"}, 32'(busy_at_edge), 32'd0);
        Busy = 1'b1;
        left = frame_len;
      end
    end
    chk({name, "_remaining"}, 32'(exp_q.size()), 32'd0);
    repeat (left) tick();
    Busy = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         n;
    int         m_wait;
    int         writes;
    int         dut_cnt;
    logic       pop;
    logic       push;
    logic       m_v;
    logic [7:0] m_pd;
    logic [7:0] mq[$];

    WR_EN = 1'b0; WR_DATA = 8'h00; Busy = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outputs", obs(), pack(1'b0, 8'h00, 1'b1, 1'b0));
`ifdef UART_TX_FEEDER_OVF_EN
    chk("reset_ovf", 32'(OVF), 32'd0);
`endif
    RST = 1'b1;

    // Single byte, Busy raised once the strobe has dropped and held 10 cycles
    add(1, 8'hA5, 0, 0, 8'h00, 0, 0);
    add(0, 8'h00, 0, 1, 8'hA5, 1, 0);
    add(0, 8'h00, 0, 0, 8'hA5, 1, 0);
    for (int i = 0; i < 10; i++) add(0, 8'h00, 1, 0, 8'hA5, 1, 0);
    add(0, 8'h00, 0, 0, 8'hA5, 1, 0);
    add(0, 8'h00, 0, 0, 8'hA5, 1, 0);
    // Busy tied low: timeout after 2 WAIT_BUSY cycles, queued byte follows
    add(1, 8'h3C, 0, 0, 8'hA5, 0, 0);
    add(1, 8'h5A, 0, 1, 8'h3C, 0, 0);
    add(0, 8'h00, 0, 0, 8'h3C, 0, 0);
    add(0, 8'h00, 0, 0, 8'h3C, 0, 0);
    add(0, 8'h00, 0, 1, 8'h5A, 1, 0);
    add(0, 8'h00, 0, 0, 8'h5A, 1, 0);
    add(0, 8'h00, 0, 0, 8'h5A, 1, 0);
    add(0, 8'h00, 0, 0, 8'h5A, 1, 0);

    foreach (vecs[i]) begin
      WR_EN = vecs[i].wr_en; WR_DATA = vecs[i].wr_data; Busy = vecs[i].busy;
      tick();
      chk($sformatf("vec%0d", i), obs(),
          pack(vecs[i].exp_valid, vecs[i].exp_pdata, vecs[i].exp_empty, vecs[i].exp_full));
    end
    WR_EN = 1'b0;

    // Burst of 8 while Busy holds off launches, then drained in order
    Busy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      WR_EN = 1'b1; WR_DATA = 8'(i);
      tick();
      chk($sformatf("burst_full%0d", i), 32'(FULL), 32'(i == 8));
      chk($sformatf("burst_empty%0d", i), 32'(EMPTY), 32'd0);
    end
    WR_EN = 1'b0; Busy = 1'b0;
    for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
    run_tx("burst", 5, 200);
    chk("burst_drained", obs(), pack(1'b0, 8'h08, 1'b1, 1'b0));

    // Overflow: plain drop, then a drop on the same edge as a pop
    Busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      WR_EN = 1'b1; WR_DATA = 8'h10 + 8'(i);
      tick();
    end
    chk("ovf_full", 32'(FULL), 32'd1);
    WR_DATA = 8'hFF;
    tick();
    chk("ovf_drop", obs(), pack(1'b0, 8'h08, 1'b0, 1'b1));
`ifdef UART_TX_FEEDER_OVF_EN
    chk("ovf_set", 32'(OVF), 32'd1);
`endif
    Busy = 1'b0;
    tick();
    chk("ovf_pop_drop", obs(), pack(1'b1, 8'h10, 1'b0, 1'b0));
    WR_EN = 1'b0; Busy = 1'b1;
    repeat (4) tick();
    Busy = 1'b0;
    for (int i = 1; i < 8; i++) exp_q.push_back(8'h10 + 8'(i));
    run_tx("ovf", 3, 200);
    n = 0;
    repeat (20) begin
      tick();
      if (TX_DATA_VALID) n++;
    end
    chk("ovf_no_extra", 32'(n), 32'd0);
    chk("ovf_empty", 32'(EMPTY), 32'd1);
`ifdef UART_TX_FEEDER_OVF_EN
    chk("ovf_sticky", 32'(OVF), 32'd1);
`endif

    // Reset in the middle of the first of three queued frames
    WR_EN = 1'b1; WR_DATA = 8'h41; tick();
    WR_DATA = 8'h42; tick();
    Busy = 1'b1;
    WR_DATA = 8'h43; tick();
    WR_EN = 1'b0; tick();
    chk("rst_pre", obs(), pack(1'b0, 8'h41, 1'b0, 1'b0));
    #2 RST = 1'b0;
    #1;
    chk("rst_async", obs(), pack(1'b0, 8'h00, 1'b1, 1'b0));
`ifdef UART_TX_FEEDER_OVF_EN
    chk("rst_ovf", 32'(OVF), 32'd0);
`endif
    tick();
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_hold%0d", i), obs(), pack(1'b0, 8'h00, 1'b1, 1'b0));
    end
    WR_EN = 1'b1; WR_DATA = 8'h77; tick();
    WR_EN = 1'b0;
    chk("rst_write", obs(), pack(1'b0, 8'h00, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_busy_hold%0d", i), obs(), pack(1'b0, 8'h00, 1'b0, 1'b0));
    end
    Busy = 1'b0;
    tick();
    chk("rst_relaunch", obs(), pack(1'b1, 8'h77, 1'b1, 1'b0));
    repeat (3) tick();

    // Wrap-around with Busy low; small timing model tracks launch slots and occupancy
    m_wait = 0; writes = 0; dut_cnt = 0; m_pd = 8'h77;
    for (int c = 0; c < 75; c++) begin
      WR_EN   = (writes < 20) && (c < 3 || (c % 3) == 0);
      WR_DATA = 8'h80 + 8'(writes);
      pop  = (m_wait == 0) && (mq.size() > 0);
      push = WR_EN && (mq.size() < 8);
      m_v  = pop;
      if (pop) begin
        m_pd   = mq.pop_front();
        m_wait = 2;
      end else if (m_wait > 0) begin
        m_wait--;
      end
      if (push) begin
        mq.push_back(WR_DATA);
        writes++;
      end
      tick();
      if (TX_DATA_VALID) dut_cnt++;
      chk($sformatf("wrap_c%0d", c), obs(), pack(m_v, m_pd, mq.size() == 0, mq.size() == 8));
    end
    WR_EN = 1'b0;
    chk("wrap_strobes", 32'(dut_cnt), 32'd20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
